snake_grid_builder: RTL and testbench
=====================================

# snake_grid_builder

Consumer end of the snake segment stream. During a shift, the snake walker emits one (x, y, exists) segment per cycle. This block rasterizes that stream into a double-buffered H×V occupancy bitmap. It flags any segment that lands on an already-occupied cell. When the frame is complete it swaps buffers, so the display/game logic sees a stable grid it can query with one-cycle latency.

## Interface
Parameters:
- H, 32, grid width in cells (power of two)
- V, 32, grid height in cells (power of two)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- frame_start  in  1  one-cycle request to begin building a new frame
- seg_valid  in  1  segment stream qualifier
- seg_x  in  logb2(H)  segment column
- seg_y  in  logb2(V)  segment row
- seg_exists  in  1  segment is an active body cell
- seg_last  in  1  final segment of the stream, qualified by seg_valid
- ready  out  1  back buffer cleared; stream is accepted
- busy  out  1  any state other than IDLE
- done  out  1  one-cycle pulse when the new frame becomes visible
- collision  out  1  duplicate cell detected in the last completed frame
- seg_count  out  logb2(H*V)+1  active segments written in the last completed frame
- overrun  out  1  one-cycle pulse when frame_start arrives outside IDLE
- qx  in  logb2(H)  query column
- qy  in  logb2(V)  query row
- q_occupied  out  1  occupancy of (qx, qy) in the front buffer

## Operation
- Storage: two H*V-bit arrays with combinational read. Cell address = {y, x}. front_sel selects the displayed array; the other array is the back buffer.
- States: INIT, IDLE, CLEAR, FILL, SWAP.
- INIT (entered on reset): clears both arrays at addresses 0..H*V-1, one per cycle. Then goes to IDLE. q_occupied is forced to 0 in INIT.
- IDLE: a frame_start pulse moves the block to CLEAR and zeroes the clear counter and the working collision and count registers.
- CLEAR: writes 0 to the back buffer at address 0..H*V-1, one per cycle. After the last address it goes to FILL.
- FILL: ready=1. Each seg_valid cycle with seg_exists=1 does three things:
  - sets back[{seg_y, seg_x}];
  - increments the working count;
  - if that bit was already 1, sets the working collision bit.
- FILL, seg_exists=0: no write and no count, but seg_last is still honoured.
- seg_valid & seg_last: the segment is processed, then the state moves to SWAP.
- SWAP (one cycle): toggles front_sel, copies the working count and collision to seg_count and collision, pulses done, then returns to IDLE.
- Rules for input arriving in other states:
  - seg_valid outside FILL is ignored.
  - frame_start outside IDLE is ignored and pulses overrun.
- Count is saturating; it cannot exceed H*V without collision.
- Reset mid-frame: the partial frame is discarded, INIT runs, and the front buffer reads empty.

## Timing
- Reset values:
  - ready=0, busy=1 (INIT), done=0, collision=0, seg_count=0, overrun=0, q_occupied=0, front_sel=0.
- INIT: exactly H*V cycles. busy falls on the following cycle.
- frame_start sampled at edge N: CLEAR occupies cycles N+1..N+H*V, and ready=1 from N+H*V+1.
- Segment accepted at edge M is visible in the back buffer for the collision check at M+1. Back-to-back segments are supported.
- seg_last accepted at edge M: SWAP during cycle M+1, and done=1 during cycle M+2. seg_count and collision are valid from M+2 until the next SWAP.
- q_occupied is registered. It reflects (qx, qy) sampled at edge K, read from the front_sel value in effect at K, and is valid after K. A query at the same edge front_sel toggles returns the old frame.
- overrun is high the cycle after the offending frame_start.

## Structure
- Shared package/header holds the state encodings (INIT, IDLE, CLEAR, FILL, SWAP) and the logb2 function used by snake-side blocks.
- The clear address counter is the existing StaticCounter #(H*V-1), reused for both INIT and CLEAR. Its overflow ends the phase.
- Everything else (FSM, arrays, query register) is in the single module.

## Test plan
- Reset, then wait: busy=1 for 1024 cycles then 0; q_occupied=0 for (0,0), (16,16), (31,31).
- frame_start, then segments (16,16), (15,16), (14,16) with last: done 2 cycles after last, seg_count=3, collision=0. Queries return 1 at those cells and 0 at (17,16).
- Segments (5,5), (6,5), (5,5) with last: collision=1, seg_count=3. Next clean frame returns collision=0.
- A stream of 4 segments with seg_exists=0 on two (last one carries seg_last): seg_count=2, swap still occurs, cleared cells read 0.
- frame_start during CLEAR and FILL: overrun pulses, state is unaffected; seg_valid during IDLE leaves the grid unchanged.
- Reset asserted mid-FILL: INIT reruns, all queries return 0, seg_count=0, and a subsequent full frame completes normally.

Source files
------------

// File: rtl/snake_grid_builder_pkg.sv
// Shared definitions for the snake-side blocks: the grid builder state
// encoding and the logb2 helper used to size coordinate/address ports.
package snake_grid_builder_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_FILL  = 3'd3,
    ST_SWAP  = 3'd4
  } sgb_state_e;

  // Number of bits needed to address n items (logb2(32) = 5, logb2(1) = 0).
  function automatic int logb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/snake_grid_builder_counter.sv
// StaticCounter: free-running 0..MAX counter with synchronous clear.
// ovf is asserted combinationally on the enabled cycle that holds MAX,
// and the counter wraps back to 0 on that same edge.
module snake_grid_builder_counter
  import snake_grid_builder_pkg::*;
#(
  parameter int MAX = 1023,
  parameter int W   = logb2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  logic [W-1:0] cnt_q;

  assign cnt = cnt_q;
  assign ovf = en && (cnt_q == W'(MAX));

  // Count while enabled; wrap on overflow, zero on clear or reset.
  always_ff @(posedge clk) begin
    if (reset || clr)  cnt_q <= '0;
    else if (en)       cnt_q <= ovf ? '0 : cnt_q + W'(1);
  end

endmodule

// File: rtl/snake_grid_builder.sv
// Rasterizes the snake segment stream into a double-buffered HxV occupancy
// bitmap, flags duplicate cells, and swaps buffers when a frame completes.
// The front buffer is queried through a registered one-cycle read port.
module snake_grid_builder
  import snake_grid_builder_pkg::*;
#(
  parameter int H = 32,
  parameter int V = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     seg_valid,
  input  logic [logb2(H)-1:0]      seg_x,
  input  logic [logb2(V)-1:0]      seg_y,
  input  logic                     seg_exists,
  input  logic                     seg_last,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic                     collision,
  output logic [logb2(H*V):0]      seg_count,
  output logic                     overrun,
  input  logic [logb2(H)-1:0]      qx,
  input  logic [logb2(V)-1:0]      qy,
  output logic                     q_occupied
);

  localparam int N  = H * V;
  localparam int AW = logb2(H) + logb2(V);
  localparam int CW = logb2(N) + 1;

  sgb_state_e state_q, state_d;

  logic [N-1:0]  mem0_q, mem1_q;
  logic          front_sel_q;
  logic [CW-1:0] wcnt_q, seg_count_q;
  logic          wcol_q, collision_q;
  logic          done_q, overrun_q, qocc_q;

  logic [AW-1:0] clr_addr;
  logic          clr_ovf;
  logic          cnt_en, cnt_clr;
  logic [AW-1:0] seg_addr, q_addr;
  logic          seg_fire, seg_set, back_bit, front_bit;

  assign seg_addr = {seg_y, seg_x};
  assign q_addr   = {qy, qx};
  assign seg_fire = (state_q == ST_FILL) && seg_valid;
  assign seg_set  = seg_fire && seg_exists;
  // front_sel=1 means mem1 is displayed, so mem0 is the back buffer.
  assign back_bit  = front_sel_q ? mem0_q[seg_addr] : mem1_q[seg_addr];
  assign front_bit = front_sel_q ? mem1_q[q_addr]   : mem0_q[q_addr];

  // One shared address sweep serves both the power-up wipe and per-frame clear.
  assign cnt_en  = (state_q == ST_INIT) || (state_q == ST_CLEAR);
  assign cnt_clr = (state_q == ST_IDLE) && frame_start;

  snake_grid_builder_counter #(.MAX(N - 1), .W(AW)) u_clr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (clr_addr),
    .ovf   (clr_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (clr_ovf)                state_d = ST_IDLE;
      ST_IDLE:  if (frame_start)            state_d = ST_CLEAR;
      ST_CLEAR: if (clr_ovf)                state_d = ST_FILL;
      ST_FILL:  if (seg_valid && seg_last)  state_d = ST_SWAP;
      ST_SWAP:                              state_d = ST_IDLE;
      default:                              state_d = ST_INIT;
    endcase
  end

  // Bitmap writes: wipe both arrays in INIT, wipe the back array in CLEAR,
  // set the segment cell in the back array during FILL.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem0_q[clr_addr] <= 1'b0;
      mem1_q[clr_addr] <= 1'b0;
    end else if (state_q == ST_CLEAR) begin
      if (front_sel_q) mem0_q[clr_addr] <= 1'b0;
      else             mem1_q[clr_addr] <= 1'b0;
    end else if (seg_set) begin
      if (front_sel_q) mem0_q[seg_addr] <= 1'b1;
      else             mem1_q[seg_addr] <= 1'b1;
    end
  end

  // Working count/collision for the frame under construction.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      wcnt_q <= '0;
      wcol_q <= 1'b0;
    end else if (seg_set) begin
      if (wcnt_q != '1) wcnt_q <= wcnt_q + CW'(1);
      if (back_bit)     wcol_q <= 1'b1;
    end
  end

  // Frame publish on SWAP plus the done/overrun pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_sel_q <= 1'b0;
      seg_count_q <= '0;
      collision_q <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_q    <= (state_q == ST_SWAP);
      overrun_q <= frame_start && (state_q != ST_IDLE);
      if (state_q == ST_SWAP) begin
        front_sel_q <= ~front_sel_q;
        seg_count_q <= wcnt_q;
        collision_q <= wcol_q;
      end
    end
  end

  // Registered query port; arrays are not yet valid during INIT.
  always_ff @(posedge clk) begin
    if (reset || state_q == ST_INIT) qocc_q <= 1'b0;
    else                             qocc_q <= front_bit;
  end

  assign ready      = (state_q == ST_FILL);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign collision  = collision_q;
  assign seg_count  = seg_count_q;
  assign overrun    = overrun_q;
  assign q_occupied = qocc_q;

endmodule

// File: tb/tb_snake_grid_builder.sv
// Scoreboarded random bench for snake_grid_builder. Frame results are
// predicted from the segment list and queued; a monitor compares them on done.
module tb_snake_grid_builder;

  localparam int H  = 32;
  localparam int V  = 32;
  localparam int N  = H * V;
  localparam int CW = 11;

  typedef struct { int x; int y; bit ex; } seg_t;
  typedef struct { int cnt; bit col; } res_t;

  logic clk = 1'b0, reset = 1'b1;
  logic frame_start = 0, seg_valid = 0, seg_exists = 0, seg_last = 0;
  logic [4:0] seg_x = 0, seg_y = 0, qx = 0, qy = 0;
  logic ready, busy, done, collision, overrun, q_occupied;
  logic [CW-1:0] seg_count;

  int checks = 0, errors = 0;
  res_t exp_q[$];
  seg_t stim[$];
  bit front_m [V][H];
  bit back_m  [V][H];

  always #5 clk = ~clk;

  snake_grid_builder #(.H(H), .V(V)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .seg_valid(seg_valid),
    .seg_x(seg_x), .seg_y(seg_y), .seg_exists(seg_exists), .seg_last(seg_last),
    .ready(ready), .busy(busy), .done(done), .collision(collision),
    .seg_count(seg_count), .overrun(overrun), .qx(qx), .qy(qy),
    .q_occupied(q_occupied)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest predicted frame.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        check("seg_count", int'(seg_count), r.cnt);
        check("collision", int'(collision), int'(r.col));
      end
    end
  end

  task automatic query(input int x, input int y);
    qx = 5'(x); qy = 5'(y);
    @(negedge clk);
    check($sformatf("q_occ(%0d,%0d)", x, y), int'(q_occupied), int'(front_m[y][x]));
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (busy && n < 2000) begin n++; @(negedge clk); end
    check("init_cycles", n, N);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; frame_start = 0; seg_valid = 0; seg_last = 0;
    @(negedge clk);
    reset = 0;
    exp_q.delete();
    foreach (front_m[y, x]) front_m[y][x] = 0;
    check("rst_ready", int'(ready), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_done", int'(done), 0);
    check("rst_collision", int'(collision), 0);
    check("rst_seg_count", int'(seg_count), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_q_occ", int'(q_occupied), 0);
    wait_init();
  endtask

  // Start a frame and wait for the back buffer to be cleared.
  task automatic start_frame(input bit ovr_clear, output bit ok);
    int n;
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    n = 0;
    if (ovr_clear) begin
      repeat (5) @(negedge clk);
      frame_start = 1;
      @(negedge clk);
      frame_start = 0;
      check("overrun_clear", int'(overrun), 1);
      @(negedge clk);
      check("overrun_clear_pulse", int'(overrun), 0);
      check("clear_not_ready", int'(ready), 0);
      n = 7;
    end
    while (!ready && n < 1200) begin @(negedge clk); n++; end
    ok = ready;
    if (!ok) check("ready_timeout", 0, 1);
    else if (!ovr_clear) check("ready_latency", n, N);
  endtask

  // Drive stim[] as one frame and predict its result from the cell list.
  task automatic run_frame(input bit ovr_clear, input bit ovr_fill);
    bit ok;
    int cnt;
    bit col;
    res_t r;
    start_frame(ovr_clear, ok);
    if (!ok) return;
    foreach (back_m[y, x]) back_m[y][x] = 0;
    cnt = 0; col = 0;
    foreach (stim[i]) begin
      if (stim[i].ex) begin
        if (back_m[stim[i].y][stim[i].x]) col = 1;
        back_m[stim[i].y][stim[i].x] = 1;
        cnt = (cnt < 2047) ? cnt + 1 : cnt;
      end
    end
    r.cnt = cnt; r.col = col;
    exp_q.push_back(r);
    foreach (stim[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        seg_valid = 0; seg_x = 5'($urandom); seg_y = 5'($urandom);
        seg_exists = 1; seg_last = 1;
        @(negedge clk);
      end
      seg_valid = 1;
      seg_x = 5'(stim[i].x); seg_y = 5'(stim[i].y);
      seg_exists = stim[i].ex;
      seg_last = (i == stim.size() - 1);
      if (ovr_fill && i == 0) frame_start = 1;
      @(negedge clk);
      frame_start = 0;
      if (ovr_fill && i == 0) check("overrun_fill", int'(overrun), 1);
    end
    seg_valid = 0; seg_last = 0;
    check("done_early", int'(done), 0);
    @(negedge clk);
    check("done_latency", int'(done), 1);
    front_m = back_m;
    @(negedge clk);
    check("idle_after_swap", int'(busy), 0);
  endtask

  task automatic query_frame(input int nrand);
    foreach (stim[i]) query(stim[i].x, stim[i].y);
    repeat (nrand) query($urandom_range(0, H - 1), $urandom_range(0, V - 1));
  endtask

  task automatic add(input int x, input int y, input bit ex);
    seg_t s;
    s.x = x; s.y = y; s.ex = ex;
    stim.push_back(s);
  endtask

  initial begin
    bit ok;
    // Power-up: reset values and INIT length.
    do_reset();
    query(0, 0); query(16, 16); query(31, 31);

    // Three-cell clean frame.
    stim.delete();
    add(16, 16, 1); add(15, 16, 1); add(14, 16, 1);
    run_frame(0, 0);
    query_frame(0);
    query(17, 16);
    check("frame_a_hit", int'(front_m[16][15]), 1);

    // Duplicate cell sets collision; overrun during CLEAR.
    stim.delete();
    add(5, 5, 1); add(6, 5, 1); add(5, 5, 1);
    run_frame(1, 0);
    query_frame(2);
    query(16, 16);

    // Clean frame after a collision; overrun during FILL.
    stim.delete();
    add(1, 2, 1); add(3, 4, 1); add(30, 31, 1);
    run_frame(0, 1);
    query_frame(2);
    query(5, 5);

    // Non-existent segments are skipped but seg_last still swaps.
    stim.delete();
    add(7, 7, 1); add(8, 8, 0); add(9, 9, 1); add(10, 10, 0);
    stim[3].ex = 0;
    run_frame(0, 0);
    query_frame(2);

    // seg_valid in IDLE must not disturb anything.
    repeat (6) begin
      seg_valid = 1; seg_exists = 1; seg_last = 1;
      seg_x = 5'($urandom); seg_y = 5'($urandom);
      @(negedge clk);
    end
    seg_valid = 0; seg_last = 0;
    check("idle_seg_busy", int'(busy), 0);
    query(8, 8); query(11, 11); query(7, 7);

    // Random frames in a small window so duplicates are likely.
    repeat (5) begin
      stim.delete();
      repeat ($urandom_range(1, 24))
        add($urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 3) != 0));
      run_frame(0, 0);
      query_frame(4);
    end

    // Reset in the middle of FILL discards the partial frame.
    stim.delete();
    add(20, 20, 1); add(21, 20, 1);
    start_frame(0, ok);
    if (ok) begin
      seg_valid = 1; seg_exists = 1; seg_x = 5'd20; seg_y = 5'd20;
      @(negedge clk);
      seg_x = 5'd21;
      @(negedge clk);
      seg_valid = 0;
    end
    do_reset();
    query(20, 20); query(21, 20); query(7, 7);
    check("post_reset_count", int'(seg_count), 0);
    stim.delete();
    add(20, 20, 1); add(0, 31, 1); add(20, 20, 1); add(2, 2, 1);
    run_frame(0, 0);
    query_frame(2);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
